// File: rtl/tetris_drop_sequencer.sv
// Game-level sequencer for a single falling Tetris piece.
// Walks each piece through spawn, gravity/hard-drop descent, lock, game-over
// evaluation and the line-clear handshake, and owns the anchor row pos_y that
// the collision and game-over checkers look at.
// All outputs are registered; the pulse outputs are decoded from the next state
// so that each one is high for exactly the one cycle the FSM spends in the
// corresponding state (or on entry to CLEAR for clr_start).

module tetris_drop_sequencer #(
  parameter logic [4:0] SPAWN_Y     = 5'd23,
  parameter logic [9:0] CLR_TIMEOUT = 10'd1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause,
  input  logic        drop_tick,
  input  logic        hard_drop,
  input  logic        can_fall,
  input  logic        go_flag,
  input  logic        clr_done,
  output logic [4:0]  pos_y,
  output logic        spawn,
  output logic        lock,
  output logic        clr_start,
  output logic        game_over,
  output logic [2:0]  state,
  output logic [15:0] piece_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SPAWN = 3'd1,
    ST_FALL  = 3'd2,
    ST_LOCK  = 3'd3,
    ST_CLEAR = 3'd4,
    ST_OVER  = 3'd5
  } state_t;

  state_t      cur_state;
  state_t      next_state;
  logic        hd_flag;
  logic [9:0]  tmo;

  logic        move_req;
  logic        blocked;
  logic        clear_exit;
  logic        new_game;

  assign state = cur_state;

  // A move is attempted on an unpaused gravity tick, or every unpaused cycle
  // once a hard drop is latched; pause freezes both sources.
  assign move_req = (cur_state == ST_FALL) && !pause && (drop_tick || hd_flag);

  // The floor behaves like an obstacle so pos_y can never wrap below row 0,
  // even if the collision checker wrongly reports free space there.
  assign blocked = !can_fall || (pos_y == 5'd0);

  // clr_start is high only in the first CLEAR cycle, so a clr_done coinciding
  // with it belongs to a stale or confused engine and is discarded.
  assign clear_exit = (clr_done && !clr_start) || (tmo == CLR_TIMEOUT);

  // start is only honoured from the idle and game-over states.
  assign new_game = start && ((cur_state == ST_IDLE) || (cur_state == ST_OVER));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  // Next-state logic; unused encodings fall back to IDLE.
  always_comb begin
    next_state = cur_state;
    case (cur_state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_SPAWN;
        end
      end
      ST_SPAWN: begin
        next_state = ST_FALL;
      end
      ST_FALL: begin
        if (move_req && blocked) begin
          next_state = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (go_flag) begin
          next_state = ST_OVER;
        end else begin
          next_state = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (clear_exit) begin
          next_state = ST_SPAWN;
        end
      end
      ST_OVER: begin
        if (start) begin
          next_state = ST_SPAWN;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Anchor row: reloaded whenever a new piece is spawned, stepped down by one
  // on each successful move, otherwise held (including through LOCK and OVER).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_y <= SPAWN_Y;
    end else if (next_state == ST_SPAWN) begin
      pos_y <= SPAWN_Y;
    end else if (move_req && !blocked) begin
      pos_y <= pos_y - 5'd1;
    end
  end

  // Hard-drop latch: armed by an unpaused hard_drop in FALL, cleared on spawn
  // and whenever the piece has left FALL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hd_flag <= 1'b0;
    end else if (cur_state == ST_FALL) begin
      if (hard_drop && !pause) begin
        hd_flag <= 1'b1;
      end
    end else begin
      hd_flag <= 1'b0;
    end
  end

  // Line-clear watchdog: counts cycles spent in CLEAR, zero everywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo <= 10'd0;
    end else if ((cur_state == ST_CLEAR) && (next_state == ST_CLEAR)) begin
      tmo <= tmo + 10'd1;
    end else begin
      tmo <= 10'd0;
    end
  end

  // Pieces locked this game; zeroed when a new game starts, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      piece_cnt <= 16'd0;
    end else if (new_game) begin
      piece_cnt <= 16'd0;
    end else if (cur_state == ST_LOCK) begin
      piece_cnt <= piece_cnt + 16'd1;
    end
  end

  // Registered pulses and status flag, decoded from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spawn     <= 1'b0;
      lock      <= 1'b0;
      clr_start <= 1'b0;
      game_over <= 1'b0;
    end else begin
      spawn     <= (next_state == ST_SPAWN);
      lock      <= (next_state == ST_LOCK);
      clr_start <= (cur_state == ST_LOCK) && (next_state == ST_CLEAR);
      game_over <= (next_state == ST_OVER);
    end
  end

endmodule
